commit_reorder: RTL and testbench
=================================

# commit_reorder

Dual-issue retirement block at the writeback end of the pipeline. It restores program order for the two lane results that the issue dispatcher may have swapped, or serialised when both instructions were memory ops. The dispatcher's `order_change`/`both_mem` flags travel through an internal delay line aligned to writeback latency. The block emits an older/younger commit pair to the register-file write ports, resolves same-destination write conflicts in favour of the younger instruction, and counts retired instructions.

## Interface
Parameters:
- `LAT`, 3: issue-to-writeback latency in cycles, minimum 1; equals the depth of the flag delay line.
- `XLEN`, 32: result data width.

Ports:
- `clk` in 1: the single clock.
- `rstn_i` in 1: reset, asynchronous and active-low.
- `stall_i` in 1: pipeline freeze.
- `flush_i` in 1: discard all in-flight flags.
- `order_change_i` in 1: dispatcher swap flag, sampled at issue.
- `both_mem_i` in 1: dispatcher split flag, sampled at issue.
- `wb0_valid_i`, `wb0_we_i` in 1 each: lane 0 writeback valid and write enable.
- `wb0_rd_i` in 5: lane 0 destination register.
- `wb0_data_i` in XLEN: lane 0 result.
- `wb1_valid_i`, `wb1_we_i`, `wb1_rd_i`, `wb1_data_i`: same as lane 0, for lane 1.
- `c0_valid_o`, `c0_we_o` out 1 each; `c0_rd_o` out 5; `c0_data_o` out XLEN: older commit slot.
- `c1_valid_o`, `c1_we_o` out 1 each; `c1_rd_o` out 5; `c1_data_o` out XLEN: younger commit slot.
- `waw_kill_o` out 1: the older slot's write was suppressed by a same-rd conflict.
- `instret_o` out 64: retired-instruction counter.

## Operation
- **Delay line.** Each stage holds `{oc, bm}`. While `stall_i`=0, the issue flags enter stage 0 and every stage advances by one. Stage `LAT-1` is aligned with the `wb*` inputs of the current cycle.
- **Reorder.** The stage `LAT-1` value selects the mapping:
  - `oc`=0: c0←lane0, c1←lane1.
  - `oc`=1: c0←lane1, c1←lane0.
- **Split.** `bm`=1 forces c1 invalid for that cycle, even if lane 1 is valid. `bm` and `oc` both set: treat as `bm` with no swap, and flag it as an assertion error in simulation.
- **Zero-register write.** `we` is forced to 0 for any slot with `rd`=0.
- **WAW conflict.** Both slots valid, both `we`=1, and equal non-zero `rd`: then `c0_we_o`=0 and `waw_kill_o`=1. The c0 slot stays valid, so it still retires.
- **instret.** Increments by `c0_valid + c1_valid` (0, 1 or 2) on each output register update, modulo 2^64.
- **Stall.** Delay line holds. Commit outputs register with both valids 0, so no double commit. `instret_o` holds.
- **Flush.** Has priority over stall. Clears every delay-line stage to 0 and registers both valids 0 next cycle. `instret_o` is unchanged.
- **Reset.** All outputs, delay-line stages and `instret_o` are 0.

## Timing
- Commit outputs are registered: `wb*` sampled at edge t appear at t+1.
- Issue flags sampled at edge t (no stall) are used with the `wb*` inputs during cycle t+LAT−1. Their commit outputs are visible after edge t+LAT.
- Each stalled cycle adds one cycle to this alignment for in-flight flags.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous). After release, the first valid commit is no earlier than one cycle after the first `wb*_valid_i`.
- `instret_o` reflects commits up to and including the current output values. Its update lands on the same edge as the commit outputs.

## Structure
- Shared package `commit_pkg`:
  - `commit_slot_t` struct: `valid`, `we`, `rd[4:0]`, `data[XLEN-1:0]`.
  - `issue_flags_t` struct: `oc`, `bm`.
  - `LAT_DEFAULT` = 3.
- Sub-module `flag_delay_line`: parameterised depth `LAT` shift register of `issue_flags_t`, with enable (`!stall_i`) and synchronous clear (`flush_i`).
- Top level holds the reorder mux, WAW logic, output registers and the 64-bit counter.

## Test plan
- **Pass-through.** LAT=3, issue `oc`=0 `bm`=0; three cycles later lane0 = {rd=5, 0xA}, lane1 = {rd=6, 0xB} → next cycle c0 = {5, 0xA}, c1 = {6, 0xB}, `instret_o` 0→2.
- **Swap.** Issue `oc`=1; at writeback lane0 = {rd=7, 0x11}, lane1 = {rd=8, 0x22} → c0 = {8, 0x22}, c1 = {7, 0x11}.
- **Split.** Issue `bm`=1, then `oc`=0 `bm`=0. Writebacks lane0 {rd=1} with lane1 garbage-valid, then lane0 {rd=2} → c1 invalid in the first commit, then c0 rd=2. `instret_o` +1 then +1.
- **WAW and x0.** Both lanes write rd=9 (0x1, 0x2) → `c0_we_o`=0, `waw_kill_o`=1, c1 writes 0x2, `instret_o` +2. Lane0 rd=0 with `we`=1 → `c0_we_o`=0.
- **Stall and flush.** Hold `stall_i` for 2 cycles mid-stream → valids 0, `instret_o` frozen, alignment preserved after release. Assert `flush_i` with `oc`=1 in flight → subsequent commits unswapped and `instret_o` unchanged by the flush.
- **Counter wrap and reset.** Preload `instret_o` to 2^64−1, commit 2 → reads 1. Drop `rstn_i` mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/commit_pkg.sv
// Shared types for the writeback reorder/commit block.
// Commit slot, issue flag bundle and default latency.
package commit_pkg;

  localparam int LAT_DEFAULT = 3;
  localparam int SLOT_XLEN   = 32;

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [4:0]           rd;
    logic [SLOT_XLEN-1:0] data;
  } commit_slot_t;

  typedef struct packed {
    logic oc;
    logic bm;
  } issue_flags_t;

endpackage

// File: rtl/flag_delay_line.sv
// Shift register carrying dispatcher flags to writeback.
// Ports: clk, rstn_i, en_i (advance), clr_i (sync clear), flags_i, flags_o.
module flag_delay_line
  import commit_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic         clk,
  input  logic         rstn_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  issue_flags_t flags_i,
  output issue_flags_t flags_o
);

  if (LAT < 1) begin : g_bad_lat
    $error("flag_delay_line: LAT must be >= 1");
  end

  issue_flags_t stage_q [LAT];

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= flags_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign flags_o = stage_q[LAT-1];

endmodule

// File: rtl/commit_reorder.sv
// Dual-issue retirement: restores program order of two lanes,
// resolves same-rd writes, registers commit ports, counts instret.
// In: clk, rstn_i, stall_i, flush_i, issue flags, wb0_*/wb1_*.
// Out: c0_* (older), c1_* (younger), waw_kill_o, instret_o.
module commit_reorder
  import commit_pkg::*;
#(
  parameter int LAT  = LAT_DEFAULT,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            order_change_i,
  input  logic            both_mem_i,
  input  logic            wb0_valid_i,
  input  logic            wb0_we_i,
  input  logic [4:0]      wb0_rd_i,
  input  logic [XLEN-1:0] wb0_data_i,
  input  logic            wb1_valid_i,
  input  logic            wb1_we_i,
  input  logic [4:0]      wb1_rd_i,
  input  logic [XLEN-1:0] wb1_data_i,
  output logic            c0_valid_o,
  output logic            c0_we_o,
  output logic [4:0]      c0_rd_o,
  output logic [XLEN-1:0] c0_data_o,
  output logic            c1_valid_o,
  output logic            c1_we_o,
  output logic [4:0]      c1_rd_o,
  output logic [XLEN-1:0] c1_data_o,
  output logic            waw_kill_o,
  output logic [63:0]     instret_o
);

  if (XLEN != SLOT_XLEN) begin : g_bad_xlen
    $error("commit_reorder: XLEN must match SLOT_XLEN");
  end

  issue_flags_t iss_flags;
  issue_flags_t wb_flags;

  assign iss_flags.oc = order_change_i;
  assign iss_flags.bm = both_mem_i;

  flag_delay_line #(.LAT(LAT)) u_dl (
    .clk     (clk),
    .rstn_i  (rstn_i),
    .en_i    (!stall_i),
    .clr_i   (flush_i),
    .flags_i (iss_flags),
    .flags_o (wb_flags)
  );

  commit_slot_t l0, l1;
  commit_slot_t s0_d, s1_d;
  logic         kill_d;
  logic         swap;

  commit_slot_t c0_q, c1_q;
  logic         kill_q;
  logic [63:0]  instret_q;

  // x0 writes and writes from empty slots are dropped at the source.
  always_comb begin
    l0.valid = wb0_valid_i;
    l0.we    = wb0_valid_i & wb0_we_i & (wb0_rd_i != 5'd0);
    l0.rd    = wb0_rd_i;
    l0.data  = wb0_data_i;
    l1.valid = wb1_valid_i;
    l1.we    = wb1_valid_i & wb1_we_i & (wb1_rd_i != 5'd0);
    l1.rd    = wb1_rd_i;
    l1.data  = wb1_data_i;
  end

  // A split pair never swaps; bm wins over a stray oc.
  assign swap = wb_flags.oc & ~wb_flags.bm;

  always_comb begin
    s0_d   = swap ? l1 : l0;
    s1_d   = swap ? l0 : l1;
    kill_d = 1'b0;
    if (wb_flags.bm) begin
      s1_d.valid = 1'b0;
      s1_d.we    = 1'b0;
    end
    // Younger write wins; the older slot still retires.
    if (s0_d.valid && s1_d.valid && s0_d.we && s1_d.we &&
        (s0_d.rd == s1_d.rd)) begin
      s0_d.we = 1'b0;
      kill_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      c0_q      <= '0;
      c1_q      <= '0;
      kill_q    <= 1'b0;
      instret_q <= '0;
    end else if (flush_i || stall_i) begin
      c0_q   <= '0;
      c1_q   <= '0;
      kill_q <= 1'b0;
    end else begin
      c0_q      <= s0_d;
      c1_q      <= s1_d;
      kill_q    <= kill_d;
      instret_q <= instret_q + {63'd0, s0_d.valid}
                             + {63'd0, s1_d.valid};
    end
  end

  assign c0_valid_o = c0_q.valid;
  assign c0_we_o    = c0_q.we;
  assign c0_rd_o    = c0_q.rd;
  assign c0_data_o  = c0_q.data;
  assign c1_valid_o = c1_q.valid;
  assign c1_we_o    = c1_q.we;
  assign c1_rd_o    = c1_q.rd;
  assign c1_data_o  = c1_q.data;
  assign waw_kill_o = kill_q;
  assign instret_o  = instret_q;

  // Dispatcher must never mark a pair as both swapped and split.
  a_oc_bm_excl : assert property (
    @(posedge clk) disable iff (!rstn_i)
    (!stall_i && !flush_i) |-> !(wb_flags.oc && wb_flags.bm)
  );

endmodule

// File: tb/tb_commit_reorder.sv
// Self-checking bench for commit_reorder.
// Vector table, directed corner sequences, random vs reference model.
module tb_commit_reorder;

  localparam int LAT = 3;

  typedef struct packed {
    logic        stall, flush, oc, bm;
    logic        v0, we0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1, we1;
    logic [4:0]  rd1;
    logic [31:0] d1;
  } in_t;

  typedef struct packed {
    logic        c0v, c0we;
    logic [4:0]  c0rd;
    logic [31:0] c0d;
    logic        c1v, c1we;
    logic [4:0]  c1rd;
    logic [31:0] c1d;
    logic        kill;
    logic [63:0] inst;
  } out_t;

  typedef struct packed {
    logic        v, we;
    logic [4:0]  rd;
    logic [31:0] d;
  } lane_t;

  typedef struct packed {
    logic oc, bm;
  } fl_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        stall_i, flush_i, order_change_i, both_mem_i;
  logic        wb0_valid_i, wb0_we_i, wb1_valid_i, wb1_we_i;
  logic [4:0]  wb0_rd_i, wb1_rd_i;
  logic [31:0] wb0_data_i, wb1_data_i;
  logic        c0_valid_o, c0_we_o, c1_valid_o, c1_we_o, waw_kill_o;
  logic [4:0]  c0_rd_o, c1_rd_o;
  logic [31:0] c0_data_o, c1_data_o;
  logic [63:0] instret_o;

  int n_checks = 0;
  int n_fail   = 0;

  fl_t         mq[$];
  logic [63:0] m_inst;

  always #5 clk = ~clk;

  commit_reorder #(.LAT(LAT), .XLEN(32)) dut (
    .clk            (clk),
    .rstn_i         (rstn_i),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .order_change_i (order_change_i),
    .both_mem_i     (both_mem_i),
    .wb0_valid_i    (wb0_valid_i),
    .wb0_we_i       (wb0_we_i),
    .wb0_rd_i       (wb0_rd_i),
    .wb0_data_i     (wb0_data_i),
    .wb1_valid_i    (wb1_valid_i),
    .wb1_we_i       (wb1_we_i),
    .wb1_rd_i       (wb1_rd_i),
    .wb1_data_i     (wb1_data_i),
    .c0_valid_o     (c0_valid_o),
    .c0_we_o        (c0_we_o),
    .c0_rd_o        (c0_rd_o),
    .c0_data_o      (c0_data_o),
    .c1_valid_o     (c1_valid_o),
    .c1_we_o        (c1_we_o),
    .c1_rd_o        (c1_rd_o),
    .c1_data_o      (c1_data_o),
    .waw_kill_o     (waw_kill_o),
    .instret_o      (instret_o)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(logic oc, logic bm,
      logic v0, logic we0, logic [4:0] rd0, logic [31:0] d0,
      logic v1, logic we1, logic [4:0] rd1, logic [31:0] d1);
    in_t r;
    r = '0;
    r.oc = oc; r.bm = bm;
    r.v0 = v0; r.we0 = we0; r.rd0 = rd0; r.d0 = d0;
    r.v1 = v1; r.we1 = we1; r.rd1 = rd1; r.d1 = d1;
    return r;
  endfunction

  function automatic out_t mk_out(
      logic c0v, logic c0we, logic [4:0] c0rd, logic [31:0] c0d,
      logic c1v, logic c1we, logic [4:0] c1rd, logic [31:0] c1d,
      logic kill, logic [63:0] inst);
    out_t r;
    r.c0v = c0v; r.c0we = c0we; r.c0rd = c0rd; r.c0d = c0d;
    r.c1v = c1v; r.c1we = c1we; r.c1rd = c1rd; r.c1d = c1d;
    r.kill = kill; r.inst = inst;
    return r;
  endfunction

  // Reference: result of one clock edge, from the retirement rules.
  function automatic out_t model_next(in_t v, fl_t f, logic [63:0] inst);
    out_t  o;
    lane_t a, b, older, younger;
    o = '0;
    o.inst = inst;
    if (v.stall || v.flush) return o;
    a = '{v.v0, v.v0 && v.we0 && (v.rd0 != 0), v.rd0, v.d0};
    b = '{v.v1, v.v1 && v.we1 && (v.rd1 != 0), v.rd1, v.d1};
    if (f.bm) begin
      older = a; younger = '0;
    end else if (f.oc) begin
      older = b; younger = a;
    end else begin
      older = a; younger = b;
    end
    if (older.v && younger.v && older.we && younger.we &&
        older.rd == younger.rd) begin
      older.we = 1'b0;
      o.kill   = 1'b1;
    end
    o.c0v = older.v;   o.c0we = older.we;
    o.c0rd = older.rd; o.c0d = older.d;
    o.c1v = younger.v;   o.c1we = younger.we;
    o.c1rd = younger.rd; o.c1d = younger.d;
    o.inst = inst + 64'(older.v) + 64'(younger.v);
    return o;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < LAT; i++) mq.push_back('0);
    m_inst = '0;
  endtask

  task automatic drive(in_t v);
    stall_i = v.stall; flush_i = v.flush;
    order_change_i = v.oc; both_mem_i = v.bm;
    wb0_valid_i = v.v0; wb0_we_i = v.we0;
    wb0_rd_i = v.rd0;   wb0_data_i = v.d0;
    wb1_valid_i = v.v1; wb1_we_i = v.we1;
    wb1_rd_i = v.rd1;   wb1_data_i = v.d1;
  endtask

  task automatic cmp_out(string tag, out_t e);
    chk({tag, ".c0v"}, 64'(c0_valid_o), 64'(e.c0v));
    chk({tag, ".c1v"}, 64'(c1_valid_o), 64'(e.c1v));
    chk({tag, ".kill"}, 64'(waw_kill_o), 64'(e.kill));
    chk({tag, ".inst"}, instret_o, e.inst);
    if (e.c0v) begin
      chk({tag, ".c0we"}, 64'(c0_we_o), 64'(e.c0we));
      chk({tag, ".c0rd"}, 64'(c0_rd_o), 64'(e.c0rd));
      chk({tag, ".c0d"}, 64'(c0_data_o), 64'(e.c0d));
    end
    if (e.c1v) begin
      chk({tag, ".c1we"}, 64'(c1_we_o), 64'(e.c1we));
      chk({tag, ".c1rd"}, 64'(c1_rd_o), 64'(e.c1rd));
      chk({tag, ".c1d"}, 64'(c1_data_o), 64'(e.c1d));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(in_t v, string tag);
    out_t e;
    drive(v);
    e = model_next(v, mq[LAT-1], m_inst);
    @(posedge clk);
    if (v.flush) begin
      foreach (mq[i]) mq[i] = '0;
    end else if (!v.stall) begin
      mq.push_front('{v.oc, v.bm});
      void'(mq.pop_back());
    end
    m_inst = e.inst;
    @(negedge clk);
    cmp_out(tag, e);
  endtask

  vec_t  tbl[10];
  in_t   v;
  in_t   idle;
  logic [63:0] saved;

  initial begin
    idle = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tbl[0] = '{mk_in(0,0, 0,0,0,0, 0,0,0,0),
               mk_out(0,0,0,0, 0,0,0,0, 0, 0)};
    tbl[1] = '{mk_in(1,0, 0,0,0,0, 0,0,0,0),
               mk_out(0,0,0,0, 0,0,0,0, 0, 0)};
    tbl[2] = '{mk_in(0,1, 0,0,0,0, 0,0,0,0),
               mk_out(0,0,0,0, 0,0,0,0, 0, 0)};
    tbl[3] = '{mk_in(0,0, 1,1,5,32'hA, 1,1,6,32'hB),
               mk_out(1,1,5,32'hA, 1,1,6,32'hB, 0, 2)};
    tbl[4] = '{mk_in(0,0, 1,1,7,32'h11, 1,1,8,32'h22),
               mk_out(1,1,8,32'h22, 1,1,7,32'h11, 0, 4)};
    tbl[5] = '{mk_in(0,0, 1,1,1,32'h33, 1,1,3,32'h44),
               mk_out(1,1,1,32'h33, 0,0,0,0, 0, 5)};
    tbl[6] = '{mk_in(0,0, 1,1,2,32'h55, 0,0,0,0),
               mk_out(1,1,2,32'h55, 0,0,0,0, 0, 6)};
    tbl[7] = '{mk_in(0,0, 1,1,9,32'h1, 1,1,9,32'h2),
               mk_out(1,0,9,32'h1, 1,1,9,32'h2, 1, 8)};
    tbl[8] = '{mk_in(0,0, 1,1,0,32'h77, 1,1,4,32'h88),
               mk_out(1,0,0,32'h77, 1,1,4,32'h88, 0, 10)};
    tbl[9] = '{mk_in(0,0, 0,0,0,0, 0,0,0,0),
               mk_out(0,0,0,0, 0,0,0,0, 0, 10)};

    rstn_i = 1'b0;
    drive(idle);
    model_reset();
    #1;
    cmp_out("reset", mk_out(0,0,0,0, 0,0,0,0, 0, 0));
    chk("reset.c0rd", 64'(c0_rd_o), 64'd0);
    chk("reset.c0d", 64'(c0_data_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].in, $sformatf("vec%0d.model", i));
      cmp_out($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Stall mid-stream: swap flag must survive two frozen cycles.
    cycle(mk_in(1,0, 0,0,0,0, 0,0,0,0), "stl.iss");
    saved = m_inst;
    for (int i = 0; i < 2; i++) begin
      v = mk_in(0,0, 1,1,12,32'hDEAD, 1,1,13,32'hBEEF);
      v.stall = 1'b1;
      cycle(v, $sformatf("stl.hold%0d", i));
      chk("stl.inst_frozen", instret_o, saved);
      chk("stl.c0v_zero", 64'(c0_valid_o), 64'd0);
    end
    cycle(idle, "stl.r0");
    cycle(idle, "stl.r1");
    cycle(mk_in(0,0, 1,1,7,32'h11, 1,1,8,32'h22), "stl.wb");
    chk("stl.swapped_c0rd", 64'(c0_rd_o), 64'd8);
    chk("stl.swapped_c1rd", 64'(c1_rd_o), 64'd7);

    // Flush discards an in-flight swap flag.
    cycle(mk_in(1,0, 0,0,0,0, 0,0,0,0), "fl.iss");
    cycle(idle, "fl.r0");
    saved = m_inst;
    v = mk_in(0,0, 1,1,14,32'h1234, 1,1,15,32'h5678);
    v.flush = 1'b1;
    cycle(v, "fl.flush");
    chk("fl.inst_kept", instret_o, saved);
    cycle(mk_in(0,0, 1,1,3,32'h66, 1,1,4,32'h99), "fl.wb");
    chk("fl.unswapped_c0rd", 64'(c0_rd_o), 64'd3);
    chk("fl.inst_after", instret_o, saved + 64'd2);

    // Counter wrap from all-ones.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    m_inst = 64'hFFFF_FFFF_FFFF_FFFF;
    cycle(mk_in(0,0, 1,1,10,32'h1, 1,1,11,32'h2), "wrap");
    chk("wrap.inst", instret_o, 64'd1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      int sel;
      v = '0;
      v.stall = ($urandom_range(0, 9) == 0);
      v.flush = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 3);
      v.oc = (sel == 1);
      v.bm = (sel == 2);
      v.v0 = $urandom_range(0, 3) != 0;
      v.we0 = $urandom_range(0, 3) != 0;
      v.rd0 = 5'($urandom_range(0, 3));
      v.d0 = $urandom;
      v.v1 = $urandom_range(0, 3) != 0;
      v.we1 = $urandom_range(0, 3) != 0;
      v.rd1 = 5'($urandom_range(0, 3));
      v.d1 = $urandom;
      cycle(v, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset mid-stream.
    cycle(mk_in(0,0, 1,1,20,32'hCAFE, 1,1,21,32'hF00D), "pre_rst");
    #2;
    rstn_i = 1'b0;
    #1;
    cmp_out("async_rst", mk_out(0,0,0,0, 0,0,0,0, 0, 0));
    chk("async_rst.c0d", 64'(c0_data_o), 64'd0);
    chk("async_rst.c1rd", 64'(c1_rd_o), 64'd0);
    drive(idle);
    model_reset();
    @(negedge clk);
    rstn_i = 1'b1;
    cycle(idle, "post_rst.idle");
    cycle(mk_in(0,0, 1,1,5,32'h42, 0,0,0,0), "post_rst.first");
    chk("post_rst.c0rd", 64'(c0_rd_o), 64'd5);
    chk("post_rst.inst", instret_o, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
